rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Parametrised rectangle-fill engine: on a start request it writes one color (solid mode) or a two-color checker pattern over an inclusive rectangle of the VGA frame buffer, one pixel per granted cycle, raster order. It generalises the full-screen clear: resolution, color width, region and pattern are all run-time or elaboration-time choices. It sits between the game controller (start/done handshake) and the frame-buffer write port, which it shares through a grant input.

## Interface
- H_RES, 640, horizontal resolution in pixels
- V_RES, 480, vertical resolution in lines
- X_W, 10, width of x coordinates (must hold H_RES-1)
- Y_W, 9, width of y coordinates (must hold V_RES-1)
- COLOR_W, 3, pixel color width
- clk  in  1  system clock, all state on rising edge
- program_reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = solid, 1 = checker; latched with start
- x0, x1  in  X_W  inclusive column bounds; latched with start
- y0, y1  in  Y_W  inclusive row bounds; latched with start
- color_a, color_b  in  COLOR_W  fill colors (color_b used only in checker); latched with start
- grant  in  1  write port granted this cycle
- busy  out  1  high in LOAD, RUN and DONE
- done  out  1  one-cycle pulse after the last pixel or an empty request
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_color  out  COLOR_W  pixel color
- vga_wren  out  1  write request

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset forces IDLE; all outputs 0.
- IDLE: start=1 -> LOAD, latching mode, bounds, colors. Start in any other state is ignored (no queueing).
- LOAD: clamp x0/x1 to H_RES-1, y0/y1 to V_RES-1. If clamped x0>x1 or y0>y1 -> DONE with no writes; else -> RUN with cursor (x0,y0).
- RUN: vga_wren=1, vga_x/vga_y = cursor. A pixel is accepted on an edge where vga_wren & grant. On accept: cursor x increments; when x==x1 it wraps to x0 and y increments; accept at (x1,y1) -> DONE. Without grant cursor, color and wren hold unchanged.
- Color: solid -> color_a. Checker -> color_a when (vga_x[0]^vga_y[0])==0, else color_b (absolute coordinates, so adjacent fills tile seamlessly).
- DONE: vga_wren=0, done=1 for exactly one cycle -> IDLE.
- Counter arithmetic in X_W/Y_W bits; clamping guarantees no overflow past H_RES-1/V_RES-1.
- vga_x/vga_y/vga_color retain their last values in IDLE (vga_wren qualifies them).

## Timing
- start high at edge k: LOAD after k, first write presented after k+1, DONE after accepting the last pixel, IDLE one edge later.
- With grant tied 1: N-pixel rectangle -> done pulse N+2 cycles after the start edge; full 640x480 -> 307202.
- Empty request: done 2 cycles after start edge, zero writes.
- done never coincides with vga_wren=1.
- program_reset asserted mid-RUN: vga_wren, busy, done drop immediately (asynchronous); after release the block is in IDLE and the aborted fill gives no done.
- Inputs other than start/grant may change freely after the start edge.

## Structure
- Shared package vga_pkg: H_RES/V_RES defaults, X_W/Y_W, COLOR_W, state encoding constants, MODE_SOLID/MODE_CHECKER.
- One sub-module, raster_cursor: x/y counter with load, advance-enable, wrap at x1 and last-pixel flag; rect_fill_engine holds FSM, clamping and color selection.

## Test plan
- Full screen, solid, color_a=3'b111, grant=1 -> 307200 writes in raster order, last at (639,479), done at start+307202.
- Rect (10,5)-(12,6), checker a=1 b=2 -> writes (10,5)=2,(11,5)=1,(12,5)=2,(10,6)=1,(11,6)=2,(12,6)=1, then done.
- Same rect with grant toggling 1,0 -> identical 6 writes, outputs held on grant=0 cycles, done after 12 RUN cycles.
- x0=700,x1=800 (clamp to 639,639), y 0..1 -> exactly 2 writes at x=639; x0=5,x1=3 -> zero writes, done at start+2.
- Start re-pulsed during RUN -> ignored, single done; program_reset at pixel 100 -> wren/busy 0 same cycle, no done, next start runs cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA fill definitions: default resolution and widths, the fill
// FSM state encoding and the fill-mode constants.
package vga_pkg;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int X_W_DEF     = 10;
  localparam int Y_W_DEF     = 9;
  localparam int COLOR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  localparam logic MODE_SOLID   = 1'b0;
  localparam logic MODE_CHECKER = 1'b1;
endpackage

// File: rtl/raster_cursor.sv
// Raster x/y cursor over an inclusive rectangle.
// Ports:
//   clk, rst          clock / async active-high reset
//   i_load            load cursor to (i_x0,i_y0) and capture bounds
//   i_adv             advance one pixel in raster order
//   i_x0, i_x1, i_y1  rectangle bounds (already clamped by the caller)
//   o_x, o_y          current cursor position
//   o_last            cursor sits on (x1,y1)
module raster_cursor #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_adv,
  input  logic [X_W-1:0] i_x0,
  input  logic [X_W-1:0] i_x1,
  input  logic [Y_W-1:0] i_y0,
  input  logic [Y_W-1:0] i_y1,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  logic [X_W-1:0] r_x, r_x0, r_x1;
  logic [Y_W-1:0] r_y, r_y1;
  logic           w_last;

  assign w_last = (r_x == r_x1) && (r_y == r_y1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (i_load) begin
      r_x  <= i_x0;
      r_y  <= i_y0;
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
    end else if (i_adv && !w_last) begin
      // The last pixel does not advance, so the outputs keep showing the
      // final written coordinate once the fill is over.
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + Y_ONE;
      end else begin
        r_x <= r_x + X_ONE;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_last;
endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: writes a solid color or a two-color checker over
// an inclusive, clamped rectangle, one pixel per granted cycle.
// Ports:
//   clk, program_reset          clock / async active-high reset
//   start, mode, x0..y1,        fill request; everything but start is
//   color_a, color_b            latched on the accepted start edge
//   grant                       frame-buffer write port granted
//   busy, done                  status / one-cycle completion pulse
//   vga_x, vga_y, vga_color,    frame-buffer write port
//   vga_wren
module rect_fill_engine
  import vga_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               program_reset,
  input  logic               start,
  input  logic               mode,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color_a,
  input  logic [COLOR_W-1:0] color_b,
  input  logic               grant,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_wren
);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  fill_state_t r_state, w_next;

  logic               r_mode;
  logic [X_W-1:0]     r_x0, r_x1;
  logic [Y_W-1:0]     r_y0, r_y1;
  logic [COLOR_W-1:0] r_ca, r_cb;

  logic [X_W-1:0] w_x0c, w_x1c;
  logic [Y_W-1:0] w_y0c, w_y1c;
  logic           w_empty, w_load, w_adv, w_last;

  // Request capture; only an idle engine takes a new request.
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      r_mode <= MODE_SOLID;
      r_x0   <= '0;
      r_x1   <= '0;
      r_y0   <= '0;
      r_y1   <= '0;
      r_ca   <= '0;
      r_cb   <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_mode <= mode;
      r_x0   <= x0;
      r_x1   <= x1;
      r_y0   <= y0;
      r_y1   <= y1;
      r_ca   <= color_a;
      r_cb   <= color_b;
    end
  end

  // Clamp to the visible frame; after this no counter can run past it.
  assign w_x0c   = (r_x0 > X_MAX) ? X_MAX : r_x0;
  assign w_x1c   = (r_x1 > X_MAX) ? X_MAX : r_x1;
  assign w_y0c   = (r_y0 > Y_MAX) ? Y_MAX : r_y0;
  assign w_y1c   = (r_y1 > Y_MAX) ? Y_MAX : r_y1;
  assign w_empty = (w_x0c > w_x1c) || (w_y0c > w_y1c);

  assign w_load = (r_state == ST_LOAD) && !w_empty;
  assign w_adv  = (r_state == ST_RUN) && grant;

  raster_cursor #(.X_W(X_W), .Y_W(Y_W)) u_cursor (
    .clk    (clk),
    .rst    (program_reset),
    .i_load (w_load),
    .i_adv  (w_adv),
    .i_x0   (w_x0c),
    .i_x1   (w_x1c),
    .i_y0   (w_y0c),
    .i_y1   (w_y1c),
    .o_x    (vga_x),
    .o_y    (vga_y),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) r_state <= ST_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    done     = 1'b0;
    vga_wren = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: w_next = w_empty ? ST_DONE : ST_RUN;
      ST_RUN: begin
        vga_wren = 1'b1;
        if (grant && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Checker parity uses absolute coordinates so neighbouring fills tile.
  assign vga_color = (r_mode == MODE_CHECKER && (vga_x[0] ^ vga_y[0])) ? r_cb : r_ca;
endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
  logic       clk = 1'b0;
  logic       program_reset;
  logic       start, mode, grant;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [2:0] color_a, color_b;
  logic       busy, done, vga_wren;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_color;

  rect_fill_engine dut (
    .clk(clk), .program_reset(program_reset), .start(start), .mode(mode),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color_a(color_a), .color_b(color_b),
    .grant(grant), .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_wren(vga_wren)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int qx[$], qy[$], qc[$];
  int done_c, run_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One fill: start at a negedge, then sample every negedge (cycle c=1 is
  // the LOAD cycle). Records accepted pixels, done cycle and RUN cycles.
  task automatic do_fill(input logic md, input int ax0, input int ax1, input int ay0,
                         input int ay1, input int ca, input int cb, input bit tog,
                         input int repulse_at, input int abort_at, input int max_c);
    int c, extra;
    bit hold_pend;
    logic [31:0] pv;
    qx.delete(); qy.delete(); qc.delete();
    done_c = -1; run_c = 0; extra = 0; hold_pend = 0; pv = '0;
    @(negedge clk);
    mode = md; x0 = 10'(ax0); x1 = 10'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
    color_a = 3'(ca); color_b = 3'(cb); start = 1'b1; grant = tog ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    // Request inputs are free to change once the start edge has passed.
    start = 1'b0; mode = ~md; x0 = 10'($urandom); x1 = 10'($urandom);
    y0 = 9'($urandom); y1 = 9'($urandom); color_a = ~color_a; color_b = ~color_b;
    c = 0;
    while (c < max_c && done_c < 0) begin
      @(negedge clk);
      c++;
      if (tog) grant = c[0];
      start = (c == repulse_at);
      if (abort_at > 0 && qx.size() == abort_at) begin
        check("abort_pre_wren", vga_wren, 1);
        program_reset = 1'b1;
        #1;
        check("abort_wren", vga_wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        program_reset = 1'b0;
        repeat (30) begin
          @(negedge clk);
          if (done) extra++;
        end
        check("abort_no_done", extra, 0);
        check("abort_idle", busy, 0);
        return;
      end
      if (hold_pend)
        check("hold_on_no_grant", {vga_wren, vga_x, vga_y, vga_color}, pv);
      if (vga_wren) run_c++;
      if (done) check("done_without_wren", vga_wren, 0);
      if (vga_wren && grant) begin
        qx.push_back(int'(vga_x)); qy.push_back(int'(vga_y)); qc.push_back(int'(vga_color));
      end
      hold_pend = vga_wren && !grant;
      pv = 32'({vga_wren, vga_x, vga_y, vga_color});
      if (done) done_c = c;
    end
    start = 1'b0; grant = 1'b1;
    check("done_seen", (done_c >= 0) ? 1 : 0, 1);
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("single_done", extra, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int err;
    int ex[6], ey[6], ec[6];
    program_reset = 1'b1; start = 0; mode = 0; grant = 0;
    x0 = 0; x1 = 0; y0 = 0; y1 = 0; color_a = 0; color_b = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wren", vga_wren, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_color", vga_color, 0);
    program_reset = 1'b0;

    // Full-width bottom band, x1 beyond the frame: 3 rows x 640 pixels.
    do_fill(0, 0, 1023, 477, 479, 7, 0, 0, 0, 0, 4000);
    check("band_count", qx.size(), 1920);
    err = 0;
    for (int i = 0; i < qx.size(); i++)
      if (qx[i] != i % 640 || qy[i] != 477 + i / 640 || qc[i] != 7) err++;
    check("band_order", err, 0);
    if (qx.size() > 0) begin
      check("band_last_x", qx[qx.size()-1], 639);
      check("band_last_y", qy[qy.size()-1], 479);
    end
    check("band_done_cycle", done_c, 1922);

    // Checker (10,5)-(12,6), a=1 b=2, grant high.
    ex = '{10, 11, 12, 10, 11, 12};
    ey = '{5, 5, 5, 6, 6, 6};
    ec = '{2, 1, 2, 1, 2, 1};
    do_fill(1, 10, 12, 5, 6, 1, 2, 0, 0, 0, 100);
    check("chk_count", qx.size(), 6);
    for (int i = 0; i < 6 && i < qx.size(); i++) begin
      check("chk_x", qx[i], ex[i]);
      check("chk_y", qy[i], ey[i]);
      check("chk_color", qc[i], ec[i]);
    end
    check("chk_done_cycle", done_c, 8);

    // Same rectangle, grant alternating 0,1 through RUN.
    do_fill(1, 10, 12, 5, 6, 1, 2, 1, 0, 0, 100);
    check("tog_count", qx.size(), 6);
    for (int i = 0; i < 6 && i < qx.size(); i++) begin
      check("tog_x", qx[i], ex[i]);
      check("tog_y", qy[i], ey[i]);
      check("tog_color", qc[i], ec[i]);
    end
    check("tog_run_cycles", run_c, 12);
    check("tog_done_cycle", done_c, 14);

    // Both x bounds beyond the frame clamp to column 639.
    do_fill(0, 700, 800, 0, 1, 5, 0, 0, 0, 0, 100);
    check("clampx_count", qx.size(), 2);
    if (qx.size() == 2) begin
      check("clampx_x0", qx[0], 639);
      check("clampx_y0", qy[0], 0);
      check("clampx_x1", qx[1], 639);
      check("clampx_y1", qy[1], 1);
      check("clampx_color", qc[1], 5);
    end
    check("clampx_done_cycle", done_c, 4);

    // Inverted x bounds: no writes, done two cycles after start.
    do_fill(0, 5, 3, 0, 0, 4, 0, 0, 0, 0, 100);
    check("empty_count", qx.size(), 0);
    check("empty_run_cycles", run_c, 0);
    check("empty_done_cycle", done_c, 2);

    // Both y bounds beyond the frame clamp to row 479: one pixel.
    do_fill(0, 2, 2, 500, 511, 6, 0, 0, 0, 0, 100);
    check("clampy_count", qx.size(), 1);
    if (qx.size() == 1) begin
      check("clampy_x", qx[0], 2);
      check("clampy_y", qy[0], 479);
    end
    check("clampy_done_cycle", done_c, 3);

    // Start pulsed again mid-RUN is ignored.
    do_fill(0, 0, 99, 10, 10, 3, 0, 0, 20, 0, 400);
    check("repulse_count", qx.size(), 100);
    check("repulse_done_cycle", done_c, 102);
    if (qx.size() > 0) check("repulse_last_x", qx[qx.size()-1], 99);

    // Reset while presenting pixel 100, then a clean follow-up fill.
    do_fill(0, 0, 639, 0, 3, 7, 0, 0, 0, 100, 3000);
    check("abort_count", qx.size(), 100);
    do_fill(1, 0, 2, 1, 1, 4, 6, 0, 0, 0, 100);
    check("post_count", qx.size(), 3);
    if (qx.size() == 3) begin
      check("post_c0", qc[0], 6);
      check("post_c1", qc[1], 4);
      check("post_c2", qc[2], 6);
      check("post_x2", qx[2], 2);
    end
    check("post_done_cycle", done_c, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
